// File: rtl/sobel_pkg.sv
// sobel_pkg: shared FSM state encoding and default sizes for the Sobel sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sobel_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DIM_W_DEF  = 12;

  // A 3x3 window needs at least three rows and three columns.
  localparam int MIN_DIM = 3;

  typedef enum logic [3:0] {
    IDLE,
    LOAD,
    SETTLE,
    FETCH,
    CALC,
    WRITE,
    MOVE,
    MOVE_WAIT,
    DONE
  } state_t;

endpackage

// File: rtl/sobel_handshake.sv
// sobel_handshake: holds a request high from entry until its ack is sampled.
// Latency: o_req rises the cycle after i_start, drops the cycle after ack.
// Backpressure: o_req is held for as long as i_ack stays low.
// Ports: i_clk, i_rst (async, active-high), i_start (enter wait),
//        i_ack, o_req (registered), o_fire (req and ack this cycle).
module sobel_handshake (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_start,
  input  logic i_ack,
  output logic o_req,
  output logic o_fire
);

  logic r_req;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_req <= 1'b0;
    end else if (i_start) begin
      r_req <= 1'b1;
    end else if (r_req && i_ack) begin
      r_req <= 1'b0;
    end
  end

  // An ack only counts while the request is actually outstanding.
  assign o_fire = r_req && i_ack;
  assign o_req  = r_req;

endmodule

// File: rtl/sobel_sequencer.sv
// sobel_sequencer: steps a window walker through fetch/calc/write/move per pixel.
// Latency: outputs registered; each step reacts one cycle after its input.
// Backpressure: waits indefinitely in FETCH/CALC/WRITE/MOVE_WAIT for acks.
// Ports: clk, reset (async, active-high); frame_start + width/length/bases in;
//        walker (load_initial/start_move/move_done/all_done), rd, calc, wr
//        handshakes; busy, frame_done, dim_err, pix_count status out.
module sobel_sequencer
  import sobel_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DIM_W  = DIM_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_start,
  input  logic [DIM_W-1:0]   width,
  input  logic [DIM_W-1:0]   length,
  input  logic [ADDR_W-1:0]  base_addr_r,
  input  logic [ADDR_W-1:0]  base_addr_w,
  output logic               load_initial,
  output logic               start_move,
  input  logic               move_done,
  input  logic               all_done,
  output logic               rd_req,
  input  logic               rd_ack,
  output logic               calc_start,
  input  logic               calc_done,
  output logic               wr_req,
  input  logic               wr_ack,
  output logic               busy,
  output logic               frame_done,
  output logic               dim_err,
  output logic [2*DIM_W-1:0] pix_count
);

  localparam logic [DIM_W-1:0]   MIN_DIM_V = DIM_W'(MIN_DIM);
  localparam logic [2*DIM_W-1:0] PIX_ONE   = {{(2*DIM_W-1){1'b0}}, 1'b1};

  state_t r_state;
  state_t w_next_state;

  logic w_dims_ok;
  logic w_accept;
  logic w_reject;
  logic w_rd_start;
  logic w_wr_start;
  logic w_rd_fire;
  logic w_wr_fire;

  logic r_load_initial;
  logic r_start_move;
  logic r_calc_start;
  logic r_busy;
  logic r_frame_done;
  logic r_dim_err;
  logic [2*DIM_W-1:0] r_pix_count;

  // Frame geometry is captured at acceptance and held for the address
  // generators that sit beside the walker; nothing in here reads it back.
  logic [DIM_W-1:0]  r_width;
  logic [DIM_W-1:0]  r_length;
  logic [ADDR_W-1:0] r_base_addr_r;
  logic [ADDR_W-1:0] r_base_addr_w;
  logic              w_unused_cfg;

  assign w_unused_cfg = ^{r_width, r_length, r_base_addr_r, r_base_addr_w};

  assign w_dims_ok = (width >= MIN_DIM_V) && (length >= MIN_DIM_V);

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_reject     = 1'b0;
    case (r_state)
      IDLE: begin
        if (frame_start) begin
          if (w_dims_ok) begin
            w_next_state = LOAD;
            w_accept     = 1'b1;
          end else begin
            w_reject = 1'b1;
          end
        end
      end
      LOAD:      w_next_state = SETTLE;
      SETTLE:    w_next_state = FETCH;
      FETCH:     if (w_rd_fire) w_next_state = CALC;
      // calc_done is honoured from the very first CALC cycle.
      CALC:      if (calc_done) w_next_state = WRITE;
      WRITE:     if (w_wr_fire) w_next_state = MOVE;
      MOVE:      w_next_state = MOVE_WAIT;
      MOVE_WAIT: begin
        if (move_done) begin
          w_next_state = all_done ? DONE : FETCH;
        end
      end
      DONE:      w_next_state = IDLE;
      default:   w_next_state = IDLE;
    endcase
  end

  // Requests are armed on state entry so they appear registered in that state.
  assign w_rd_start = (w_next_state == FETCH) && (r_state != FETCH);
  assign w_wr_start = (w_next_state == WRITE) && (r_state != WRITE);

  sobel_handshake u_rd_hs (
    .i_clk   (clk),
    .i_rst   (reset),
    .i_start (w_rd_start),
    .i_ack   (rd_ack),
    .o_req   (rd_req),
    .o_fire  (w_rd_fire)
  );

  sobel_handshake u_wr_hs (
    .i_clk   (clk),
    .i_rst   (reset),
    .i_start (w_wr_start),
    .i_ack   (wr_ack),
    .o_req   (wr_req),
    .o_fire  (w_wr_fire)
  );

  // Outputs are decoded from the next state and registered, so each one
  // lines up exactly with the state it belongs to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= IDLE;
      r_load_initial <= 1'b0;
      r_start_move   <= 1'b0;
      r_calc_start   <= 1'b0;
      r_busy         <= 1'b0;
      r_frame_done   <= 1'b0;
      r_dim_err      <= 1'b0;
      r_pix_count    <= '0;
      r_width        <= '0;
      r_length       <= '0;
      r_base_addr_r  <= '0;
      r_base_addr_w  <= '0;
    end else begin
      r_state        <= w_next_state;
      r_load_initial <= (w_next_state == LOAD);
      r_start_move   <= (w_next_state == MOVE);
      r_calc_start   <= (w_next_state == CALC) && (r_state != CALC);
      r_busy         <= (w_next_state != IDLE);
      r_frame_done   <= (w_next_state == DONE);
      r_dim_err      <= w_reject;
      if (w_accept) begin
        r_width       <= width;
        r_length      <= length;
        r_base_addr_r <= base_addr_r;
        r_base_addr_w <= base_addr_w;
        r_pix_count   <= '0;
      end else if (w_wr_fire && !(&r_pix_count)) begin
        r_pix_count <= r_pix_count + PIX_ONE;
      end
    end
  end

  assign load_initial = r_load_initial;
  assign start_move   = r_start_move;
  assign calc_start   = r_calc_start;
  assign busy         = r_busy;
  assign frame_done   = r_frame_done;
  assign dim_err      = r_dim_err;
  assign pix_count    = r_pix_count;

endmodule

// File: tb/tb_sobel_sequencer.sv
module tb_sobel_sequencer;

  localparam int ADDR_W = 8;
  localparam int DIM_W  = 12;

  logic               clk = 1'b0;
  logic               reset;
  logic               frame_start;
  logic [DIM_W-1:0]   width;
  logic [DIM_W-1:0]   length;
  logic [ADDR_W-1:0]  base_addr_r;
  logic [ADDR_W-1:0]  base_addr_w;
  logic               load_initial;
  logic               start_move;
  logic               move_done;
  logic               all_done;
  logic               rd_req;
  logic               rd_ack;
  logic               calc_start;
  logic               calc_done;
  logic               wr_req;
  logic               wr_ack;
  logic               busy;
  logic               frame_done;
  logic               dim_err;
  logic [2*DIM_W-1:0] pix_count;

  always #5 clk = ~clk;

  sobel_sequencer #(.ADDR_W(ADDR_W), .DIM_W(DIM_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .frame_start  (frame_start),
    .width        (width),
    .length       (length),
    .base_addr_r  (base_addr_r),
    .base_addr_w  (base_addr_w),
    .load_initial (load_initial),
    .start_move   (start_move),
    .move_done    (move_done),
    .all_done     (all_done),
    .rd_req       (rd_req),
    .rd_ack       (rd_ack),
    .calc_start   (calc_start),
    .calc_done    (calc_done),
    .wr_req       (wr_req),
    .wr_ack       (wr_ack),
    .busy         (busy),
    .frame_done   (frame_done),
    .dim_err      (dim_err),
    .pix_count    (pix_count)
  );

  int checks = 0;
  int errors = 0;

  // Environment configuration (written by the test, read by the responders).
  int cfg_rd_d, cfg_calc_d, cfg_wr_d, cfg_mv_d, cfg_total;
  bit stray_en;

  // Responder and monitor state.
  int rd_cnt, wr_cnt, calc_cnt, mv_cnt, walk_idx;
  bit calc_pend, mv_pend, prev_rd, prev_wr;
  int n_load, n_rd, n_calc, n_wr, n_move, n_done, n_dimerr, n_overlap;
  int rd_run, rd_run_max, wr_run, wr_run_max;

  typedef struct {
    int w; int l; int rd; int cd; int wd; int md;
    int exp_pix; int exp_cyc;
  } vec_t;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    n_load = 0; n_rd = 0; n_calc = 0; n_wr = 0; n_move = 0;
    n_done = 0; n_dimerr = 0; n_overlap = 0;
    rd_run_max = 0; wr_run_max = 0;
  endtask

  // Reference model: interior pixels of a frame and the cycle at which
  // frame_done is seen, counted from the accepting edge. Per pixel the walk
  // costs FETCH(rd+1) + CALC(cd+1) + WRITE(wd+1) + MOVE(1) + MOVE_WAIT(md+1),
  // plus LOAD and SETTLE before and the DONE cycle itself.
  function automatic int model_pixels(input int w, input int l);
    return (w - 2) * (l - 2);
  endfunction

  function automatic int model_cycles(input int n, input int rd, input int cd,
                                      input int wd, input int md);
    return 3 + n * (rd + cd + wd + md + 5);
  endfunction

  // Walker / memory / gradient-unit models plus protocol monitor.
  initial begin
    rd_ack = 0; wr_ack = 0; calc_done = 0; move_done = 0; all_done = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        rd_ack = 0; wr_ack = 0; calc_done = 0; move_done = 0; all_done = 0;
        rd_cnt = 0; wr_cnt = 0; calc_pend = 0; mv_pend = 0;
        prev_rd = 0; prev_wr = 0; rd_run = 0; wr_run = 0;
      end else begin
        if (load_initial) n_load++;
        if (rd_req && !prev_rd) n_rd++;
        if (wr_req && !prev_wr) n_wr++;
        if (calc_start) n_calc++;
        if (start_move) n_move++;
        if (frame_done) n_done++;
        if (dim_err) n_dimerr++;
        if (calc_start && (rd_req || wr_req)) n_overlap++;
        if (start_move && (rd_req || wr_req || calc_start)) n_overlap++;
        rd_run = rd_req ? rd_run + 1 : 0;
        wr_run = wr_req ? wr_run + 1 : 0;
        if (rd_run > rd_run_max) rd_run_max = rd_run;
        if (wr_run > wr_run_max) wr_run_max = wr_run;
        prev_rd = rd_req;
        prev_wr = wr_req;

        if (rd_req) begin
          rd_cnt++;
          rd_ack = (rd_cnt > cfg_rd_d);
        end else begin
          rd_cnt = 0;
          rd_ack = stray_en ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        if (wr_req) begin
          wr_cnt++;
          wr_ack = (wr_cnt > cfg_wr_d);
        end else begin
          wr_cnt = 0;
          wr_ack = stray_en ? 1'($urandom_range(0, 1)) : 1'b0;
        end

        if (calc_start) begin
          calc_pend = 1; calc_cnt = cfg_calc_d;
        end
        if (calc_pend) begin
          if (calc_cnt == 0) begin
            calc_done = 1; calc_pend = 0;
          end else begin
            calc_done = 0; calc_cnt--;
          end
        end else begin
          calc_done = stray_en ? 1'($urandom_range(0, 1)) : 1'b0;
        end

        if (load_initial) walk_idx = 0;
        if (start_move) begin
          mv_pend = 1; mv_cnt = cfg_mv_d + 1; walk_idx++;
        end
        if (mv_pend) begin
          if (mv_cnt == 0) begin
            move_done = 1; all_done = (walk_idx >= cfg_total); mv_pend = 0;
          end else begin
            move_done = 0; all_done = 0; mv_cnt--;
          end
        end else begin
          move_done = stray_en ? 1'($urandom_range(0, 1)) : 1'b0;
          all_done  = stray_en ? 1'($urandom_range(0, 1)) : 1'b0;
        end
      end
    end
  end

  // Drives one frame from the current (negedge+1) point; frame_start is seen
  // on the very next rising edge. Optionally pokes frame_start while busy.
  task automatic run_frame(input int w, input int l, input int rd, input int cd,
                           input int wd, input int md, input bit poke,
                           output int cyc, output bit seen);
    cfg_rd_d = rd; cfg_calc_d = cd; cfg_wr_d = wd; cfg_mv_d = md;
    cfg_total = model_pixels(w, l);
    clear_mon();
    width = DIM_W'(w); length = DIM_W'(l);
    base_addr_r = ADDR_W'($urandom); base_addr_w = ADDR_W'($urandom);
    frame_start = 1;
    cyc = 0; seen = 0;
    while (!seen && cyc < 3000) begin
      @(negedge clk); #1;
      cyc++;
      frame_start = 0;
      if (poke && cyc == 4) begin frame_start = 1; width = 2; length = 2; end
      if (poke && cyc == 6) begin frame_start = 1; width = 6; length = 6; end
      if (frame_done) seen = 1;
    end
  endtask

  task automatic check_frame(input string tag, input int w, input int l,
                             input int rd, input int cd, input int wd, input int md,
                             input bit poke, input int exp_pix, input int exp_cyc);
    int cyc;
    bit seen;
    run_frame(w, l, rd, cd, wd, md, poke, cyc, seen);
    check({tag, "_done_seen"}, seen, 1);
    check({tag, "_latency"}, cyc, exp_cyc);
    check({tag, "_pix"}, pix_count, exp_pix);
    check({tag, "_loads"}, n_load, 1);
    check({tag, "_rd_reqs"}, n_rd, exp_pix);
    check({tag, "_calcs"}, n_calc, exp_pix);
    check({tag, "_wr_reqs"}, n_wr, exp_pix);
    check({tag, "_moves"}, n_move, exp_pix);
    check({tag, "_dim_err"}, n_dimerr, 0);
    check({tag, "_rd_hold"}, rd_run_max, rd + 1);
    check({tag, "_wr_hold"}, wr_run_max, wd + 1);
    check({tag, "_overlap"}, n_overlap, 0);
    repeat (3) begin @(negedge clk); #1; end
    check({tag, "_frame_done_cnt"}, n_done, 1);
    check({tag, "_idle_busy"}, busy, 0);
    check({tag, "_pix_hold"}, pix_count, exp_pix);
  endtask

  vec_t vecs[5];
  int   last_pix;

  initial begin
    reset = 1; frame_start = 0; width = 0; length = 0;
    base_addr_r = 0; base_addr_w = 0; stray_en = 0;
    cfg_rd_d = 0; cfg_calc_d = 0; cfg_wr_d = 0; cfg_mv_d = 0; cfg_total = 0;
    clear_mon();

    vecs[0] = '{w:5, l:5, rd:0, cd:0, wd:0, md:0, exp_pix:9, exp_cyc:48};
    vecs[1] = '{w:3, l:3, rd:1, cd:2, wd:0, md:1, exp_pix:1, exp_cyc:12};
    vecs[2] = '{w:4, l:6, rd:0, cd:3, wd:2, md:0, exp_pix:8, exp_cyc:83};
    vecs[3] = '{w:6, l:3, rd:2, cd:0, wd:1, md:2, exp_pix:4, exp_cyc:43};
    vecs[4] = '{w:3, l:8, rd:4, cd:0, wd:0, md:0, exp_pix:6, exp_cyc:57};

    repeat (2) begin @(negedge clk); #1; end
    check("rst_busy", busy, 0);
    check("rst_pix", pix_count, 0);
    check("rst_outs", {load_initial, start_move, rd_req, calc_start, wr_req,
                       frame_done, dim_err}, 0);
    reset = 0;

    for (int i = 0; i < 5; i++) begin
      check_frame($sformatf("vec%0d", i), vecs[i].w, vecs[i].l, vecs[i].rd,
                  vecs[i].cd, vecs[i].wd, vecs[i].md, 1'b0,
                  vecs[i].exp_pix, vecs[i].exp_cyc);
    end
    last_pix = vecs[4].exp_pix;

    // Undersized frame is rejected with a one-cycle dim_err.
    clear_mon();
    width = 2; length = 8; frame_start = 1;
    @(negedge clk); #1;
    frame_start = 0;
    check("dimerr_pulse", dim_err, 1);
    check("dimerr_busy", busy, 0);
    @(negedge clk); #1;
    check("dimerr_drop", dim_err, 0);
    check("dimerr_no_load", n_load, 0);
    check("dimerr_pix_hold", pix_count, last_pix);
    width = 8; length = 2; frame_start = 1;
    @(negedge clk); #1;
    frame_start = 0;
    check("dimerr_len_pulse", dim_err, 1);
    repeat (2) begin @(negedge clk); #1; end
    check("dimerr_count", n_dimerr, 2);

    // frame_start while busy is ignored.
    check_frame("poke", 4, 5, 0, 0, 0, 0, 1'b1, 6, model_cycles(6, 0, 0, 0, 0));

    // Reset while waiting in WRITE, then a frame straight out of reset.
    begin
      bit got_wr;
      got_wr = 0;
      cfg_rd_d = 0; cfg_calc_d = 0; cfg_wr_d = 6; cfg_mv_d = 0; cfg_total = 4;
      width = 4; length = 4; frame_start = 1;
      for (int c = 0; c < 100 && !got_wr; c++) begin
        @(negedge clk); #1;
        frame_start = 0;
        if (wr_req) got_wr = 1;
      end
      check("rstw_wr_seen", got_wr, 1);
      reset = 1;
      #1;
      check("rstw_wr_req", wr_req, 0);
      check("rstw_busy", busy, 0);
      check("rstw_pix", pix_count, 0);
      @(negedge clk); #1;
      reset = 0;
      check_frame("post_rst", 4, 4, 0, 0, 0, 0, 1'b0, 4, model_cycles(4, 0, 0, 0, 0));
    end

    // Randomized frames with stray acks outside their waiting states.
    stray_en = 1;
    for (int i = 0; i < 6; i++) begin
      int w, l, rd, cd, wd, md, n;
      w  = $urandom_range(3, 7); l  = $urandom_range(3, 7);
      rd = $urandom_range(0, 3); cd = $urandom_range(0, 3);
      wd = $urandom_range(0, 3); md = $urandom_range(0, 3);
      n  = model_pixels(w, l);
      check_frame($sformatf("rnd%0d", i), w, l, rd, cd, wd, md, 1'b0,
                  n, model_cycles(n, rd, cd, wd, md));
    end
    stray_en = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/sobel_sequencer.md
SOBEL_SEQUENCER -- requirements
Module: sobel_sequencer

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 8, pixel address width; DIM_W, default 12, frame dimension width.
REQ-002 Ports SHALL be as follows; one clock; reset is asynchronous and active-high:
  clk  in  1  system clock, all state on rising edge
  reset  in  1  asynchronous active-high reset
  frame_start  in  1  one-cycle request to process a frame
  width  in  DIM_W  frame rows; sampled on accepted frame_start
  length  in  DIM_W  frame columns; sampled on accepted frame_start
  base_addr_r  in  ADDR_W  first read address; sampled on accepted frame_start
  base_addr_w  in  ADDR_W  first write address; sampled on accepted frame_start
  load_initial  out  1  pulse to walker: load start position
  start_move  out  1  pulse to walker: advance one pixel
  move_done  in  1  walker: move complete
  all_done  in  1  walker: frame traversal finished
  rd_req  out  1  request 3x3 window fetch at current position
  rd_ack  in  1  window fetch complete
  calc_start  out  1  pulse: start gradient computation
  calc_done  in  1  gradient result valid
  wr_req  out  1  request result write at current position
  wr_ack  in  1  write accepted
  busy  out  1  frame in progress
  frame_done  out  1  one-cycle pulse at normal frame end
  dim_err  out  1  one-cycle pulse, frame_start rejected
  pix_count  out  2*DIM_W  pixels written in current/last frame

Function
REQ-003 FSM states SHALL be IDLE, LOAD, SETTLE, FETCH, CALC, WRITE, MOVE, MOVE_WAIT, DONE.
REQ-004 IDLE: frame_start with width>=3 and length>=3 -> LOAD, register width/length/base addresses, clear pix_count; otherwise frame_start -> dim_err pulse next cycle, stay IDLE.
REQ-005 LOAD: load_initial high exactly one cycle -> SETTLE; SETTLE: one idle cycle -> FETCH.
REQ-006 FETCH: rd_req held high until cycle rd_ack sampled high; rd_req low the cycle after -> CALC.
REQ-007 CALC: calc_start high exactly one cycle on entry; wait calc_done -> WRITE; calc_done in the entry cycle SHALL be accepted.
REQ-008 WRITE: wr_req held high until wr_ack sampled high; on ack pix_count increments by 1 -> MOVE.
REQ-009 MOVE: start_move high exactly one cycle -> MOVE_WAIT; start_move never asserted in any other state.
REQ-010 MOVE_WAIT: move_done and all_done together -> DONE; move_done alone -> FETCH; neither -> stay.
REQ-011 DONE: frame_done high one cycle -> IDLE.
REQ-012 busy SHALL be high in every state except IDLE.
REQ-013 frame_start outside IDLE SHALL be ignored (no dim_err, no restart).
REQ-014 rd_ack, calc_done, wr_ack, move_done arriving outside their waiting state SHALL be ignored.
REQ-015 pix_count SHALL saturate at all-ones and hold its value in IDLE until next accepted frame_start.
REQ-016 Outputs SHALL be registered; no combinational input-to-output path.

Reset
REQ-017 Reset SHALL force IDLE and all outputs 0 (pix_count 0) immediately, mid-frame included.
REQ-018 First frame_start SHALL be honoured on the first rising edge after reset deasserts.

Structure
REQ-019 Shared package sobel_pkg SHALL hold the FSM state enum and ADDR_W/DIM_W defaults.
REQ-020 One sub-module, sobel_handshake (req/ack holder reused for rd and wr), is natural; all else flat.

Verification
REQ-021 5x5 frame, walker model, zero-latency acks -> 9 rd_req/calc_start/wr_req, 9 start_move, pix_count=9, one frame_done.
REQ-022 width=2,length=8 frame_start -> dim_err pulse one cycle later, busy stays 0, no load_initial.
REQ-023 rd_ack delayed 4 cycles -> rd_req high 5 cycles, no calc_start until ack seen.
REQ-024 reset asserted in WRITE with wr_req high -> wr_req, busy low same cycle, IDLE; new 4x4 frame then gives pix_count=4.
REQ-025 frame_start pulsed while busy -> ignored; pix_count and frame_done unchanged from single-frame run.
